fft_stage_controller: RTL and testbench

Sequencing controller for the radix-2 butterfly unit in the in-place FFT engine. For each butterfly it generates the read and write addresses of the dual-port sample memory and the twiddle ROM address. It runs all log2(N) stages, tracking the fixed memory + BFU pipeline latency so that write-back lines up with the butterfly outputs. It also inserts drain bubbles between stages to prevent read-after-write hazards.

---
 rtl/fft_pkg.sv | 11 +
 rtl/clk_delay.sv | 22 ++
 rtl/fft_addr_gen.sv | 19 +
 rtl/fft_stage_controller.sv | 100 ++++++++++
 tb/tb_fft_stage_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type and default geometry/latency constants for the FFT controller
package fft_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
   localparam int LOG2N_DEF = 4;
   localparam int MEM_LATENCY_DEF = 1;
   localparam int BFU_LATENCY_DEF = 2;
   function automatic int pipe_of(input int mem_latency, input int bfu_latency);
      return mem_latency + bfu_latency;
   endfunction
   localparam int PIPE_DEF = pipe_of(MEM_LATENCY_DEF, BFU_LATENCY_DEF);
endpackage

// File: rtl/clk_delay.sv
// clk_delay: DEPTH-cycle register delay line with asynchronous flush
module clk_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] line [DEPTH];
   // shift register; clear empties every stage so nothing in flight emerges
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < DEPTH; i++) line[i] <= '0;
      end else begin
         line[0] <= d;
         for (int i = 1; i < DEPTH; i++) line[i] <= line[i-1];
      end
   end
   assign q = line[DEPTH-1];
endmodule

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: maps (stage, butterfly index) to DIT read addresses and twiddle ROM address
module fft_addr_gen #(
   parameter int LOG2N = 4
) (
   input  logic [LOG2N-1:0] s,
   input  logic [LOG2N-2:0] k,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr
);
   logic [LOG2N-2:0] pos;
   // pos = k mod 2^s; a = grp*2*span + pos collapses to 2k - pos
   always_comb begin
      pos = k & ~({(LOG2N-1){1'b1}} << s);
      rd_addr_a = {k, 1'b0} - {1'b0, pos};
      rd_addr_b = rd_addr_a + (LOG2N'(1) << s);
      tw_addr = pos << (LOG2N'(LOG2N-1) - s);
   end
endmodule

// File: rtl/fft_stage_controller.sv
// fft_stage_controller: sequences radix-2 butterflies over all stages with latency-matched write-back
module fft_stage_controller
   import fft_pkg::*;
#(
   parameter int LOG2N = LOG2N_DEF,
   parameter int MEM_LATENCY = MEM_LATENCY_DEF,
   parameter int BFU_LATENCY = BFU_LATENCY_DEF
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [LOG2N-1:0] stage,
   output logic             rd_en,
   output logic [LOG2N-1:0] rd_addr_a,
   output logic [LOG2N-1:0] rd_addr_b,
   output logic [LOG2N-2:0] tw_addr,
   output logic             wr_en,
   output logic [LOG2N-1:0] wr_addr_a,
   output logic [LOG2N-1:0] wr_addr_b
);
   localparam int PIPE = pipe_of(MEM_LATENCY, BFU_LATENCY);
   localparam int HALF = 1 << (LOG2N-1);
   localparam int CW = $clog2(PIPE) + 1;
   state_t state;
   logic [LOG2N-1:0] k;
   logic [CW-1:0] cnt;
   logic [LOG2N-1:0] gen_s, gen_a, gen_b;
   logic [LOG2N-2:0] gen_k, gen_tw;
   // address generator looks at the butterfly to be presented next cycle
   always_comb begin
      gen_s = (state == DRAIN) ? stage + LOG2N'(1) : (state == ISSUE) ? stage : '0;
      gen_k = (state == ISSUE) ? k[LOG2N-2:0] : '0;
   end
   fft_addr_gen #(.LOG2N(LOG2N)) u_addr (
      .s(gen_s),
      .k(gen_k),
      .rd_addr_a(gen_a),
      .rd_addr_b(gen_b),
      .tw_addr(gen_tw)
   );
   clk_delay #(.WIDTH(1 + 2*LOG2N), .DEPTH(PIPE)) u_wr (
      .clk(clk),
      .clear(clear),
      .d({rd_en, rd_addr_a, rd_addr_b}),
      .q({wr_en, wr_addr_a, wr_addr_b})
   );
   // FSM with registered outputs; k holds the index of the next butterfly to issue
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state <= IDLE;
         k <= '0;
         cnt <= '0;
         busy <= 1'b0;
         done <= 1'b0;
         stage <= '0;
         rd_en <= 1'b0;
         rd_addr_a <= '0;
         rd_addr_b <= '0;
         tw_addr <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state <= ISSUE;
               busy <= 1'b1;
               stage <= '0;
               rd_en <= 1'b1;
               {rd_addr_a, rd_addr_b, tw_addr} <= {gen_a, gen_b, gen_tw};
               k <= LOG2N'(1);
            end
            ISSUE: if (k == LOG2N'(HALF)) begin
               state <= DRAIN;
               rd_en <= 1'b0;
               cnt <= '0;
            end else begin
               {rd_addr_a, rd_addr_b, tw_addr} <= {gen_a, gen_b, gen_tw};
               k <= k + LOG2N'(1);
            end
            DRAIN: if (cnt != CW'(PIPE-1)) begin
               cnt <= cnt + CW'(1);
            end else if (stage == LOG2N'(LOG2N-1)) begin
               state <= DONE;
               done <= 1'b1;
            end else begin
               state <= ISSUE;
               stage <= stage + LOG2N'(1);
               rd_en <= 1'b1;
               {rd_addr_a, rd_addr_b, tw_addr} <= {gen_a, gen_b, gen_tw};
               k <= LOG2N'(1);
            end
            default: begin
               state <= IDLE;
               done <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_fft_stage_controller.sv
// tb_fft_stage_controller: timeline and FFT-result checks of the stage controller against a behavioural model
module tb_fft_stage_controller;
   import fft_pkg::*;
   localparam int L = 4, N = 16, HALF = 8, P = PIPE_DEF, SLOT = HALF + P, DONE_T = L * SLOT + 1;
   localparam int L2 = 3, HALF2 = 4, P2 = 5, SLOT2 = HALF2 + P2, DONE2 = L2 * SLOT2 + 1;
   localparam real PI = 3.14159265358979323846;
   logic clk = 1'b0, clear = 1'b1, start = 1'b0, start2 = 1'b0;
   logic busy, done, rd_en, wr_en;
   logic [3:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
   logic [2:0] tw_addr;
   logic busy2, done2, rd_en2, wr_en2;
   logic [2:0] stage2, ra2, rb2, wa2, wb2;
   logic [1:0] tw2;
   int total = 0, bad = 0;
   real mr[16], mi[16], xr[16], xi[16];

   fft_stage_controller dut (
      .clk(clk), .clear(clear), .start(start), .busy(busy), .done(done), .stage(stage),
      .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
      .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
   );
   fft_stage_controller #(.LOG2N(3), .MEM_LATENCY(2), .BFU_LATENCY(3)) dut2 (
      .clk(clk), .clear(clear), .start(start2), .busy(busy2), .done(done2), .stage(stage2),
      .rd_en(rd_en2), .rd_addr_a(ra2), .rd_addr_b(rb2), .tw_addr(tw2),
      .wr_en(wr_en2), .wr_addr_a(wa2), .wr_addr_b(wb2)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic int exp_rd(input int t, input int l, input int half, input int slot);
      int p = t - 1;
      return (p >= 0 && p / slot < l && p % slot < half) ? 1 : 0;
   endfunction
   function automatic int exp_span(input int t, input int slot);
      return 1 << ((t - 1) / slot);
   endfunction
   function automatic int exp_a(input int t, input int slot);
      int span = exp_span(t, slot);
      int k = (t - 1) % slot;
      return (k / span) * 2 * span + k % span;
   endfunction
   function automatic int exp_tw(input int t, input int l, input int slot);
      int s = (t - 1) / slot;
      return ((t - 1) % slot % (1 << s)) << (l - 1 - s);
   endfunction
   function automatic int bitrev4(input int n);
      return ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
   endfunction
   function automatic real rabs(input real v);
      return v < 0.0 ? -v : v;
   endfunction

   task automatic load_mem(input bit impulse);
      for (int n = 0; n < N; n++) begin
         xr[n] = impulse ? (n == 0 ? 1.0 : 0.0) : real'($urandom_range(0, 16)) - 8.0;
         xi[n] = impulse ? 0.0 : real'($urandom_range(0, 16)) - 8.0;
         mr[bitrev4(n)] = xr[n];
         mi[bitrev4(n)] = xi[n];
      end
   endtask

   task automatic check_fft(input string name);
      for (int k = 0; k < N; k++) begin
         real sr = 0.0, si = 0.0;
         for (int n = 0; n < N; n++) begin
            real ang = 2.0 * PI * real'(n * k) / real'(N);
            sr += xr[n] * $cos(ang) + xi[n] * $sin(ang);
            si += xi[n] * $cos(ang) - xr[n] * $sin(ang);
         end
         total++;
         if (rabs(mr[k] - sr) > 1e-6 || rabs(mi[k] - si) > 1e-6) begin
            bad++;
            $display("FAIL %s bin %0d: got (%f,%f) want (%f,%f)", name, k, mr[k], mi[k], sr, si);
         end
      end
   endtask

   task automatic run(input string name);
      int nrd = 0, nwr = 0, er, ew;
      logic [10:0] want;
      real qar[$], qai[$], qbr[$], qbi[$];
      start = 1'b1;
      step;
      for (int t = 1; t <= DONE_T; t++) begin
         er = exp_rd(t, L, HALF, SLOT);
         ew = exp_rd(t - P, L, HALF, SLOT);
         total++;
         if (rd_en !== er[0] || (er == 1 && {stage, rd_addr_a, rd_addr_b, tw_addr} !==
             {4'((t - 1) / SLOT), 4'(exp_a(t, SLOT)), 4'(exp_a(t, SLOT) + exp_span(t, SLOT)), 3'(exp_tw(t, L, SLOT))})) begin
            bad++;
            $display("FAIL %s read cycle %0d: got en=%b s=%0d a=%0d b=%0d tw=%0d want en=%0d", name, t, rd_en, stage, rd_addr_a, rd_addr_b, tw_addr, er);
         end
         total++;
         if (wr_en !== ew[0] || (ew == 1 && {wr_addr_a, wr_addr_b} !==
             {4'(exp_a(t - P, SLOT)), 4'(exp_a(t - P, SLOT) + exp_span(t - P, SLOT))})) begin
            bad++;
            $display("FAIL %s write cycle %0d: got en=%b a=%0d b=%0d want en=%0d", name, t, wr_en, wr_addr_a, wr_addr_b, ew);
         end
         total++;
         if ({busy, done} !== {1'b1, t == DONE_T}) begin
            bad++;
            $display("FAIL %s status cycle %0d: got busy=%b done=%b want busy=1 done=%b", name, t, busy, done, t == DONE_T);
         end
         if (t == 1 || t == 2 || t == 13 || t == 41) begin
            want = t == 1 ? {4'd0, 4'd1, 3'd0} : t == 2 ? {4'd2, 4'd3, 3'd0} : t == 13 ? {4'd1, 4'd3, 3'd4} : {4'd7, 4'd15, 3'd7};
            total++;
            if ({rd_addr_a, rd_addr_b, tw_addr} !== want) begin
               bad++;
               $display("FAIL %s plan point cycle %0d: got %h want %h", name, t, {rd_addr_a, rd_addr_b, tw_addr}, want);
            end
         end
         if (rd_en === 1'b1) begin
            real ang = 2.0 * PI * real'(tw_addr) / real'(N);
            real wre = $cos(ang), wim = -$sin(ang);
            real tr = wre * mr[rd_addr_b] - wim * mi[rd_addr_b];
            real ti = wre * mi[rd_addr_b] + wim * mr[rd_addr_b];
            qar.push_back(mr[rd_addr_a] + tr);
            qai.push_back(mi[rd_addr_a] + ti);
            qbr.push_back(mr[rd_addr_a] - tr);
            qbi.push_back(mi[rd_addr_a] - ti);
            nrd++;
         end
         if (wr_en === 1'b1) begin
            nwr++;
            if (qar.size() != 0) begin
               mr[wr_addr_a] = qar.pop_front();
               mi[wr_addr_a] = qai.pop_front();
               mr[wr_addr_b] = qbr.pop_front();
               mi[wr_addr_b] = qbi.pop_front();
            end
         end
         start = (t == 5 || t == DONE_T || $urandom_range(0, 3) == 0);
         step;
      end
      start = 1'b0;
      total++;
      if ({busy, done, rd_en, wr_en} !== 4'b0) begin
         bad++;
         $display("FAIL %s after done: got busy=%b done=%b rd=%b wr=%b want all 0", name, busy, done, rd_en, wr_en);
      end
      total++;
      if (nrd != L * HALF || nwr != L * HALF) begin
         bad++;
         $display("FAIL %s counts: got rd=%0d wr=%0d want %0d each", name, nrd, nwr, L * HALF);
      end
   endtask

   task automatic test_reset;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b} !== '0 ||
          {busy2, done2, stage2, rd_en2, ra2, rb2, tw2, wr_en2, wa2, wb2} !== '0) begin
         bad++;
         $display("FAIL reset outputs: got %h / %h want 0", {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b},
                  {busy2, done2, stage2, rd_en2, ra2, rb2, tw2, wr_en2, wa2, wb2});
      end
      clear = 1'b0;
      repeat (3) step;
      total++;
      if ({busy, rd_en, wr_en, done} !== 4'b0) begin
         bad++;
         $display("FAIL idle without start: got busy=%b rd=%b wr=%b done=%b want 0", busy, rd_en, wr_en, done);
      end
   endtask

   task automatic test_fft_impulse;
      load_mem(1'b1);
      run("impulse");
      check_fft("impulse");
   endtask

   task automatic test_back_to_back;
      load_mem(1'b0);
      run("first");
      check_fft("first");
      load_mem(1'b0);
      run("back_to_back");
      check_fft("back_to_back");
   endtask

   task automatic test_clear;
      start = 1'b1;
      step;
      start = 1'b0;
      repeat (14) step;
      #1 clear = 1'b1;
      #1;
      total++;
      if ({busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b} !== '0) begin
         bad++;
         $display("FAIL clear async: got %h want 0", {busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr, wr_en, wr_addr_a, wr_addr_b});
      end
      #2 clear = 1'b0;
      for (int t = 0; t < 20; t++) begin
         step;
         total++;
         if ({busy, rd_en, wr_en, done} !== 4'b0) begin
            bad++;
            $display("FAIL after clear %0d: got busy=%b rd=%b wr=%b done=%b want 0", t, busy, rd_en, wr_en, done);
         end
      end
      load_mem(1'b0);
      run("restart");
      check_fft("restart");
   endtask

   task automatic test_small_config;
      int nrd = 0, nwr = 0, er, ew;
      start2 = 1'b1;
      step;
      start2 = 1'b0;
      for (int t = 1; t <= DONE2 + 1; t++) begin
         er = exp_rd(t, L2, HALF2, SLOT2);
         ew = exp_rd(t - P2, L2, HALF2, SLOT2);
         total++;
         if (rd_en2 !== er[0] || (er == 1 && {stage2, ra2, rb2, tw2} !==
             {3'((t - 1) / SLOT2), 3'(exp_a(t, SLOT2)), 3'(exp_a(t, SLOT2) + exp_span(t, SLOT2)), 2'(exp_tw(t, L2, SLOT2))})) begin
            bad++;
            $display("FAIL small read cycle %0d: got en=%b s=%0d a=%0d b=%0d tw=%0d want en=%0d", t, rd_en2, stage2, ra2, rb2, tw2, er);
         end
         total++;
         if (wr_en2 !== ew[0] || (ew == 1 && {wa2, wb2} !==
             {3'(exp_a(t - P2, SLOT2)), 3'(exp_a(t - P2, SLOT2) + exp_span(t - P2, SLOT2))})) begin
            bad++;
            $display("FAIL small write cycle %0d: got en=%b a=%0d b=%0d want en=%0d", t, wr_en2, wa2, wb2, ew);
         end
         total++;
         if ({busy2, done2} !== {t <= DONE2, t == DONE2}) begin
            bad++;
            $display("FAIL small status cycle %0d: got busy=%b done=%b want busy=%b done=%b", t, busy2, done2, t <= DONE2, t == DONE2);
         end
         if (t == 22) begin
            total++;
            if ({ra2, rb2, tw2} !== {3'd3, 3'd7, 2'd3}) begin
               bad++;
               $display("FAIL small stage2 k3: got a=%0d b=%0d tw=%0d want a=3 b=7 tw=3", ra2, rb2, tw2);
            end
         end
         nrd += rd_en2 === 1'b1 ? 1 : 0;
         nwr += wr_en2 === 1'b1 ? 1 : 0;
         step;
      end
      total++;
      if (nrd != 12 || nwr != 12) begin
         bad++;
         $display("FAIL small counts: got rd=%0d wr=%0d want 12 each", nrd, nwr);
      end
   endtask

   initial begin
      test_reset;
      test_fft_impulse;
      test_back_to_back;
      test_clear;
      test_small_config;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
